uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8N1 UART transmitter between NUM_REQ byte-producing requesters.
- Accepts one byte per grant and drives the transmitter's trmt/TX_DATA interface.
- Tracks the transmitter's tx_done flag through clear and set, then returns a completion pulse to the owning requester.
- Sits between the command/telemetry producers and the UART transmitter; shares rst_n with it.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// No logic: enums and widths only.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_CLR  = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int BYTE_W          = 8;
   localparam int DEFAULT_TIMEOUT = 32768;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for the UART arbiter.
// master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import uart_arb_pkg::*;

   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ*BYTE_W-1:0]   req_data;
   logic [NUM_REQ-1:0]          ack;
   logic [NUM_REQ-1:0]          cmplt;
   logic                        trmt;
   logic [BYTE_W-1:0]           tx_data;
   logic                        tx_done;
   logic                        busy;
   logic [$clog2(NUM_REQ)-1:0]  grant_id;
   logic                        tx_err;

   modport master (
      input  req, req_data, tx_done,
      output ack, cmplt, trmt, tx_data, busy, grant_id, tx_err
   );

   modport slave (
      output req, req_data, tx_done,
      input  ack, cmplt, trmt, tx_data, busy, grant_id, tx_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req scanning up from ptr, wrapping.
// Zero latency; any_req low means winner is don't-care (driven 0).
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       any_req
);
   localparam int IDW = $clog2(NUM_REQ);

   int             idx;
   logic [IDW-1:0] idx_w;

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = IDW'(idx);
         if (!any_req && req[idx_w]) begin
            winner  = idx_w;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 transmitter: ack 1 cycle after req sampled, trmt 1 later, one byte in flight.
// req is only looked at in IDLE; UART_ARB_TIMEOUT_EN adds a per-frame watchdog that raises tx_err.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.master  bus
);
   localparam int IDW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   arb_state_t         state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     grant_q, grant_d;
   logic [BYTE_W-1:0]  data_q, data_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] cmplt_q, cmplt_d;
   logic               trmt_q, trmt_d;
   logic               err_q, err_d;

   logic [IDW-1:0]     win_id;
   logic               any_req;
   logic [IDW-1:0]     next_ptr;
   logic               wd_hit;
   logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = bus.req_data[g*BYTE_W +: BYTE_W];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .winner  (win_id),
      .any_req (any_req)
   );

   // Pointer always moves past the owner, whether the frame completed or timed out.
   assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wd_q, wd_d;

   assign wd_hit = (state_q == WAIT_CLR || state_q == WAIT_DONE) && (wd_q == TO_LAST);

   always_comb begin
      wd_d = wd_q;
      if (state_q == LOAD)
         wd_d = '0;
      else if (state_q == WAIT_CLR || state_q == WAIT_DONE)
         wd_d = wd_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      cmplt_d = '0;
      trmt_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d        = win_id;
               data_d         = req_bytes[win_id];
               ack_d[win_id]  = 1'b1;
               state_d        = LOAD;
            end
         end
         LOAD: begin
            trmt_d  = 1'b1;
            state_d = WAIT_CLR;
         end
         // tx_done may still be high from the previous frame; wait for the clear first.
         WAIT_CLR: begin
            if (wd_hit) begin
               err_d   = 1'b1;
               ptr_d   = next_ptr;
               state_d = IDLE;
            end else if (!bus.tx_done) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (wd_hit) begin
               err_d   = 1'b1;
               ptr_d   = next_ptr;
               state_d = IDLE;
            end else if (bus.tx_done) begin
               cmplt_d[grant_q] = 1'b1;
               ptr_d            = next_ptr;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         cmplt_q <= '0;
         trmt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         cmplt_q <= cmplt_d;
         trmt_q  <= trmt_d;
         err_q   <= err_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.cmplt    = cmplt_q;
   assign bus.trmt     = trmt_q;
   assign bus.tx_data  = data_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.grant_id = grant_q;
   assign bus.tx_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vectors, corner sequences, and randomized traffic
// checked by a transaction-level round-robin scoreboard with a behavioural transmitter.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   localparam int N   = 4;
   localparam int IDW = $clog2(N);
   localparam int TO  = 100;

   localparam int W_ACK   = 0;
   localparam int W_CMPLT = 1;
   localparam int W_ERR   = 2;
   localparam int W_IDLE  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural transmitter ----------------
   bit   xmit_auto;
   int   clr_dly;
   int   frame_len;
   int   since = -1;
   int   xt;
   logic tx_done_auto = 1'b1;
   logic tx_done_man;

   assign bus.tx_done = xmit_auto ? tx_done_auto : tx_done_man;

   // clears clr_dly edges after trmt is seen, sets frame_len edges after the clear, then holds
   always @(posedge clk) begin
      if (xmit_auto) begin
         xt = bus.trmt ? 0 : ((since >= 0) ? since + 1 : -1);
         since <= xt;
         if (xt == clr_dly) tx_done_auto <= 1'b0;
         else if (xt == clr_dly + frame_len) begin
            tx_done_auto <= 1'b1;
            since        <= -1;
         end
      end else begin
         since <= -1;
      end
   end

   // ---------------- transaction scoreboard ----------------
   bit             sb_en;
   logic [N-1:0]   last_req;
   logic [N*8-1:0] last_data;
   int m_ptr, owner, since_ack, trmt_cnt, grants, sb_e;
   bit in_flight;

   always @(posedge clk) begin
      last_req  <= bus.req;
      last_data <= bus.req_data;
   end

   function automatic int rr_ref(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[IDW'((p + k) % N)]) return (p + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (sb_en && rst_n) begin
         if (in_flight) since_ack++;
         if (bus.trmt) begin
            trmt_cnt++;
            chk("sb_trmt_lat", since_ack, 1);
         end
         if (bus.ack != '0) begin
            chk("sb_overlap", in_flight, 0);
            chk("sb_no_err", bus.tx_err, 0);
            sb_e = rr_ref(last_req, m_ptr);
            chk("sb_ack", bus.ack, (sb_e < 0) ? 0 : (1 << sb_e));
            if (sb_e >= 0) begin
               chk("sb_byte", bus.tx_data, 8'(last_data >> (8 * sb_e)));
               chk("sb_gid", bus.grant_id, sb_e);
               owner = sb_e;
            end
            in_flight = 1'b1;
            since_ack = 0;
            trmt_cnt  = 0;
            grants++;
         end
         if (bus.cmplt != '0) begin
            chk("sb_cmplt_inflight", in_flight, 1);
            chk("sb_cmplt", bus.cmplt, 1 << owner);
            chk("sb_trmt_once", trmt_cnt, 1);
            chk("sb_done_seen", bus.tx_done, 1);
            in_flight = 1'b0;
            m_ptr     = (owner + 1) % N;
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic bit cond_hi(input int which);
      case (which)
         W_ACK:   return bus.ack != '0;
         W_CMPLT: return bus.cmplt != '0;
         W_ERR:   return bus.tx_err;
         default: return !bus.busy;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input int budget, output int waited);
      waited = -1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (cond_hi(which)) begin
            waited = c;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [31:0]  data;
      int           exp_id;
      logic [7:0]   exp_byte;
   } vec_t;

   vec_t vt [13];

   // ---------------- main sequence ----------------
   initial begin
      int w, cm_j, tcnt, k_err;
      bit cm_any, busy_any;

      vt[0]  = '{4'b1000, 32'hD3C2B1A0, 3, 8'hD3};
      vt[1]  = '{4'b1111, 32'h13121110, 0, 8'h10};
      vt[2]  = '{4'b1111, 32'h13121110, 1, 8'h11};
      vt[3]  = '{4'b1111, 32'h13121110, 2, 8'h12};
      vt[4]  = '{4'b1111, 32'h13121110, 3, 8'h13};
      vt[5]  = '{4'b1111, 32'h13121110, 0, 8'h10};
      vt[6]  = '{4'b1000, 32'hD3C2B1A0, 3, 8'hD3};
      vt[7]  = '{4'b1010, 32'hD3C2B1A0, 1, 8'hB1};
      vt[8]  = '{4'b1010, 32'hD3C2B1A0, 3, 8'hD3};
      vt[9]  = '{4'b0110, 32'hD3C2B1A0, 1, 8'hB1};
      vt[10] = '{4'b0001, 32'hD3C2B1A0, 0, 8'hA0};
      vt[11] = '{4'b0101, 32'hD3C2B1A0, 2, 8'hC2};
      vt[12] = '{4'b0101, 32'hD3C2B1A0, 0, 8'hA0};

      rst_n = 1'b0;
      bus.req = '0;
      bus.req_data = '0;
      xmit_auto = 1'b1;
      tx_done_man = 1'b1;
      clr_dly = 0;
      frame_len = 6;
      sb_en = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_ack", bus.ack, 0);
      chk("rst_cmplt", bus.cmplt, 0);
      chk("rst_trmt", bus.trmt, 0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_busy", bus.busy, 0);
      chk("rst_gid", bus.grant_id, 0);
      chk("rst_err", bus.tx_err, 0);
      rst_n = 1'b1;

      // single requester, exact latencies
      @(negedge clk);
      bus.req = 4'b0100;
      bus.req_data = 32'h00A5_0000;
      @(negedge clk);
      chk("t1_ack", bus.ack, 4'b0100);
      chk("t1_data", bus.tx_data, 8'hA5);
      chk("t1_gid", bus.grant_id, 2);
      chk("t1_busy", bus.busy, 1);
      chk("t1_trmt_early", bus.trmt, 0);
      bus.req = '0;
      @(negedge clk);
      chk("t1_trmt", bus.trmt, 1);
      chk("t1_ack_pulse", bus.ack, 0);
      wait_for("t1_cmplt_wait", W_CMPLT, 60, w);
      chk("t1_cmplt_lat", w, frame_len + 2);
      chk("t1_cmplt", bus.cmplt, 4'b0100);
      chk("t1_data_hold", bus.tx_data, 8'hA5);
      @(negedge clk);
      chk("t1_idle", bus.busy, 0);
      chk("t1_cmplt_pulse", bus.cmplt, 0);

      // table: contention order and pointer wrap (pointer now 3)
      for (int v = 0; v < 13; v++) begin
         @(negedge clk);
         bus.req = vt[v].req;
         bus.req_data = vt[v].data;
         wait_for($sformatf("vec%0d_ack_wait", v), W_ACK, 10, w);
         chk($sformatf("vec%0d_ack", v), bus.ack, 1 << vt[v].exp_id);
         chk($sformatf("vec%0d_gid", v), bus.grant_id, vt[v].exp_id);
         chk($sformatf("vec%0d_byte", v), bus.tx_data, vt[v].exp_byte);
         bus.req = '0;
         wait_for($sformatf("vec%0d_cmplt_wait", v), W_CMPLT, 40, w);
         chk($sformatf("vec%0d_cmplt", v), bus.cmplt, 1 << vt[v].exp_id);
      end

      // stale tx_done with a late clear (pointer now 1)
      xmit_auto = 1'b0;
      tx_done_man = 1'b1;
      @(negedge clk);
      bus.req = 4'b0010;
      bus.req_data = 32'h0000_3C00;
      wait_for("t4_ack_wait", W_ACK, 10, w);
      chk("t4_ack", bus.ack, 4'b0010);
      bus.req = '0;
      cm_j = -1;
      tcnt = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (bus.trmt) tcnt++;
         if (bus.cmplt != '0 && cm_j < 0) begin
            cm_j = j;
            chk("t4_cmplt", bus.cmplt, 4'b0010);
         end
         tx_done_man = (j >= 2 && j < 7) ? 1'b0 : 1'b1;
      end
      chk("t4_cmplt_time", cm_j, 8);
      chk("t4_trmt_once", tcnt, 1);

      // reset while waiting for done (pointer now 2)
      @(negedge clk);
      bus.req = 4'b0100;
      bus.req_data = 32'h0077_0000;
      wait_for("t5_ack_wait", W_ACK, 10, w);
      chk("t5_ack", bus.ack, 4'b0100);
      bus.req = '0;
      @(negedge clk);
      tx_done_man = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_busy_pre", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_trmt", bus.trmt, 0);
      chk("t5_rst_data", bus.tx_data, 8'h00);
      chk("t5_rst_gid", bus.grant_id, 0);
      tx_done_man = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cm_any = 1'b0;
      busy_any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         cm_any = cm_any | (bus.cmplt != '0);
         busy_any = busy_any | bus.busy;
      end
      chk("t5_no_cmplt", cm_any, 0);
      chk("t5_stay_idle", busy_any, 0);
      xmit_auto = 1'b1;
      bus.req = 4'b0011;
      bus.req_data = 32'h0000_2211;
      wait_for("t5_ack2_wait", W_ACK, 10, w);
      chk("t5_ptr_zero", bus.ack, 4'b0001);
      chk("t5_byte", bus.tx_data, 8'h11);
      bus.req = '0;
      wait_for("t5_cmplt_wait", W_CMPLT, 40, w);
      chk("t5_cmplt", bus.cmplt, 4'b0001);

`ifdef UART_ARB_TIMEOUT_EN
      // watchdog: tx_done never rises (pointer now 1)
      xmit_auto = 1'b0;
      tx_done_man = 1'b1;
      @(negedge clk);
      bus.req = 4'b0010;
      bus.req_data = 32'h0000_5A00;
      wait_for("t6_ack_wait", W_ACK, 10, w);
      bus.req = '0;
      @(negedge clk);
      chk("t6_trmt", bus.trmt, 1);
      tx_done_man = 1'b0;
      k_err = -1;
      cm_any = 1'b0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         cm_any = cm_any | (bus.cmplt != '0);
         if (bus.tx_err) begin
            k_err = k;
            break;
         end
      end
      chk("t6_err_time", k_err, TO);
      chk("t6_no_cmplt", cm_any, 0);
      chk("t6_idle", bus.busy, 0);
      @(negedge clk);
      chk("t6_err_pulse", bus.tx_err, 0);
      xmit_auto = 1'b1;
      bus.req = 4'b1111;
      bus.req_data = 32'h1312_1110;
      wait_for("t6_ack2_wait", W_ACK, 10, w);
      chk("t6_next_owner", bus.ack, 4'b0100);
      bus.req = '0;
      wait_for("t6_cmplt_wait", W_CMPLT, 40, w);
`else
      k_err = 0;
      chk("t6_err_tied", bus.tx_err, 0);
`endif

      // randomized traffic against the scoreboard
      rst_n = 1'b0;
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      in_flight = 1'b0;
      grants = 0;
      sb_en = 1'b1;
      for (int p = 0; p < 2; p++) begin
         clr_dly = p;
         frame_len = 4 + p;
         for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
               if (bus.ack[i]) begin
                  if ($urandom_range(0, 1) == 1) bus.req_data[i*8 +: 8] = 8'($urandom);
                  else bus.req[i] = 1'b0;
               end else if (!bus.req[i]) begin
                  if ($urandom_range(0, 3) == 0) begin
                     bus.req[i] = 1'b1;
                     bus.req_data[i*8 +: 8] = 8'($urandom);
                  end
               end else if ($urandom_range(0, 31) == 0) begin
                  bus.req[i] = 1'b0;
               end
            end
         end
         bus.req = '0;
         @(negedge clk);
         wait_for("rand_drain", W_IDLE, 60, w);
      end
      @(negedge clk);
      sb_en = 1'b0;
      chk("sb_in_flight_end", in_flight, 0);
      chk("sb_activity", grants > 50, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
